uart_rx: RTL and testbench

UART receiver with 16x oversampling; the receive-side counterpart of the team's UART transmitter.
- Frame: 1 start bit (0), FRAME_WIDTH data bits LSB first, optional even-parity bit, stop bit of SB_TICK ticks.
- Shares the baud-rate s_tick with the transmitter.
- Delivers parallel data with a one-cycle done pulse and per-frame error flags.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by the receiver and available to the transmitter.
package uart_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned LAST_TICK  = 15;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, registered outputs.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter int unsigned SB_TICK     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_tick,
  input  logic                   rx,
  output logic [FRAME_WIDTH-1:0] rx_dout,
  output logic                   rx_done_tick,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   rx_busy
);

  // s must reach SB_TICK-1 for stop bits longer than one bit period
  localparam int unsigned S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int unsigned N_W = $clog2(FRAME_WIDTH) + 1;

  logic                   rx_s;
  state_t                 state_q, state_d;
  logic [S_W-1:0]         s_q, s_d;
  logic [N_W-1:0]         n_q, n_d;
  logic [FRAME_WIDTH-1:0] b_q, b_d;
  logic [FRAME_WIDTH-1:0] dout_d;
  logic                   done_d;
  logic                   perr_d;
  logic                   ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   par_bad_q, par_bad_d;
`endif

  uart_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      rx_dout      <= dout_d;
      rx_done_tick <= done_d;
      parity_err   <= perr_d;
      frame_err    <= ferr_d;
      // registered from next state so it tracks state_q exactly
      rx_busy      <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = rx_dout;
    done_d  = 1'b0;
    ferr_d  = frame_err;
`ifdef UART_RX_PARITY_EN
    perr_d    = parity_err;
    par_d     = par_q;
    par_bad_d = par_bad_q;
`else
    perr_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_W'(MID_TICK)) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = '0;
`ifdef UART_RX_PARITY_EN
              par_d   = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_W'(LAST_TICK)) begin
            s_d = '0;
            b_d = {rx_s, b_q[FRAME_WIDTH-1:1]};
`ifdef UART_RX_PARITY_EN
            par_d = par_q ^ rx_s;
`endif
            if (n_q == N_W'(FRAME_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_W'(LAST_TICK)) begin
            s_d       = '0;
            par_bad_d = (rx_s != par_q);
            state_d   = STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = IDLE;
            s_d     = '0;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a monitor
// pops and compares on every rx_done_tick. Honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int FW      = 8;
  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

  typedef struct {
    logic [FW-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_tick = 1'b0;
  logic          rx = 1'b1;
  logic [FW-1:0] rx_dout;
  logic          rx_done_tick;
  logic          parity_err;
  logic          frame_err;
  logic          rx_busy;

  int   checks = 0;
  int   errors = 0;
  int   tick_cnt = 0;
  exp_t exp_q[$];

  uart_rx #(.FRAME_WIDTH(FW), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_cnt = (tick_cnt + 1) % 4;
    s_tick   = (tick_cnt == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // Expected outcome comes straight from what is put on the line.
  task automatic send_frame(input logic [FW-1:0] d, input logic pflip,
                            input logic bad_stop, input int gap_bits);
    exp_t e;
    e.d  = d;
    e.fe = bad_stop;
`ifdef UART_RX_PARITY_EN
    e.pe = pflip;
`else
    e.pe = 1'b0;
`endif
    exp_q.push_back(e);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < FW; i++) drive(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ pflip, BIT_CLK);
`endif
    if (bad_stop) begin
      // low across the stop sample point, then back to idle
      drive(1'b0, 48);
      drive(1'b1, 16);
    end else begin
      drive(1'b1, BIT_CLK);
    end
    drive(1'b1, gap_bits * BIT_CLK);
  endtask

  // Monitor: compare every done pulse against the oldest expected frame.
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_done) check("done_one_cycle", 32'(rx_done_tick), 32'd0);
      if (rx_done_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got rx_dout 0x%0h with no frame expected at %0t",
                   rx_dout, $time);
        end else begin
          e = exp_q.pop_front();
          check("rx_dout", 32'(rx_dout), 32'(e.d));
          check("parity_err", 32'(parity_err), 32'(e.pe));
          check("frame_err", 32'(frame_err), 32'(e.fe));
        end
      end
      prev_done = (rx_done_tick === 1'b1);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d pending frames expected 0",
             exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int busy_clks;
    logic [FW-1:0] d;
    logic pflip, bad;
    int gap;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dout", 32'(rx_dout), 32'd0);
    check("reset_done", 32'(rx_done_tick), 32'd0);
    check("reset_perr", 32'(parity_err), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    drive(1'b1, 2 * BIT_CLK);

    // clean, bad parity, clean-clears, bad stop, recovery
    send_frame(8'hA5, 1'b0, 1'b0, 1);
    send_frame(8'h3C, 1'b1, 1'b0, 1);
    send_frame(8'h01, 1'b0, 1'b0, 1);
    send_frame(8'hFF, 1'b0, 1'b1, 2);
    send_frame(8'h00, 1'b0, 1'b0, 1);

    // short low pulse must be rejected as a glitch
    busy_clks = 0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy) busy_clks++;
    end
    rx = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_busy) busy_clks++;
    end
    check("glitch_busy_short", 32'(busy_clks >= 25 && busy_clks <= 36), 32'd1);
    check("glitch_busy_clear", 32'(rx_busy), 32'd0);

    // reset in the 4th data bit of 0x55 aborts that frame
    d = 8'h55;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive(d[i], BIT_CLK);
    drive(d[3], 30);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_dout", 32'(rx_dout), 32'd0);
    check("midreset_perr", 32'(parity_err), 32'd0);
    check("midreset_ferr", 32'(frame_err), 32'd0);
    check("midreset_busy", 32'(rx_busy), 32'd0);
    drive(1'b1, 12 * BIT_CLK);
    send_frame(8'h81, 1'b0, 1'b0, 1);

    // back-to-back with no idle gap
    send_frame(8'h12, 1'b0, 1'b0, 0);
    send_frame(8'h34, 1'b0, 1'b0, 1);

    // randomized traffic
    for (int k = 0; k < 16; k++) begin
      d     = FW'($urandom_range(0, 255));
      pflip = ($urandom_range(0, 7) == 0);
      bad   = ($urandom_range(0, 7) == 0);
      gap   = bad ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      send_frame(d, pflip, bad, gap);
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("all_frames_delivered", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(rx_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
